// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer reader.
package fb_pkg;

    localparam int HDISP_DEF     = 800;
    localparam int VDISP_DEF     = 480;
    localparam int BURST_DEF     = 64;
    localparam int BYTES_PER_PIX = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD,
        ST_GAP
    } fb_state_e;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; the master drives the request, the slave returns data and ack.
interface wshb_if;

    logic [31:0] adr;
    logic [31:0] dat_sm;
    logic [31:0] dat_ms;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        output adr, dat_ms, cyc, stb, we, sel, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  adr, dat_ms, cyc, stb, we, sel, cti, bte,
        output dat_sm, ack
    );

endinterface

// File: rtl/fb_addr_cnt.sv
// Raster x/y pixel counters with byte-address generation; address is combinational from the counters.
// Counters move only on inc_i, so the caller's stall (no ack) simply holds the address.
module fb_addr_cnt
    import fb_pkg::*;
#(
    parameter int HDISP = HDISP_DEF,
    parameter int VDISP = VDISP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic        eof_o,
    output logic [31:0] adr_o
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_last;
    logic          y_last;

    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);
    assign eof_o  = x_last && y_last;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (inc_i) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign adr_o = (32'(x_q) + 32'(y_q) * 32'(HDISP)) * 32'(BYTES_PER_PIX);

endmodule

// File: rtl/fb_reader.sv
// Streams a frame from memory over Wishbone into a FIFO; each acked word is pushed the same cycle.
// Stops requesting on fifo_afull (after the in-flight ack) and idles the bus one cycle every BURST acks.
module fb_reader
    import fb_pkg::*;
#(
    parameter int HDISP = HDISP_DEF,
    parameter int VDISP = VDISP_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    wshb_if.master      wshb_ifm,
    output logic [31:0] fifo_wdata,
    output logic        fifo_write,
    input  logic        fifo_afull,
    output logic        frame_done
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

    fb_state_e     state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          acked;
    logic          cnt_clr;
    logic          eof;
    logic [31:0]   adr;

    assign acked = (state_q == ST_READ) && wshb_ifm.ack;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                burst_d = '0;
                if (enable) state_d = ST_READ;
            end
            ST_READ: begin
                if (wshb_ifm.ack) begin
                    burst_d = burst_q + 1'b1;
                    if (!enable) begin
                        state_d = ST_IDLE;
                        burst_d = '0;
                    end else if (fifo_afull) begin
                        state_d = ST_HOLD;
                        burst_d = '0;
                    end else if (burst_q == BURST_LAST) begin
                        state_d = ST_GAP;
                        burst_d = '0;
                    end
                end
            end
            ST_HOLD: begin
                burst_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!fifo_afull) begin
                    state_d = ST_READ;
                end
            end
            ST_GAP: begin
                burst_d = '0;
                state_d = ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Sitting in IDLE keeps the counters at zero, so every new read-out starts at pixel 0.
    assign cnt_clr = (state_q == ST_IDLE) || (acked && !enable);

    fb_addr_cnt #(
        .HDISP(HDISP),
        .VDISP(VDISP)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (acked),
        .eof_o (eof),
        .adr_o (adr)
    );

    assign wshb_ifm.stb    = (state_q == ST_READ);
    assign wshb_ifm.cyc    = (state_q == ST_READ);
    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.we     = 1'b0;
    assign wshb_ifm.sel    = 4'b1111;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.dat_ms = 32'd0;

    assign fifo_write = acked;
    assign fifo_wdata = wshb_ifm.dat_sm;
    assign frame_done = acked && eof;

endmodule

// File: tb/tb_fb_reader.sv
// Directed and randomized bench for fb_reader with a pixel-level reference model.
module tb_fb_reader;

    localparam int HD   = 4;
    localparam int VD   = 3;
    localparam int BR   = 5;
    localparam int NPIX = HD * VD;
    localparam int W_OFF  = 0;
    localparam int W_ROOM = 1;
    localparam int W_GAP  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        fifo_afull;
    logic        frame_done;

    int n_err = 0;
    int n_chk = 0;
    int dly;

    wshb_if bus ();

    fb_reader #(
        .HDISP(HD),
        .VDISP(VD),
        .BURST(BR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wshb_ifm   (bus),
        .fifo_wdata (fifo_wdata),
        .fifo_write (fifo_write),
        .fifo_afull (fifo_afull),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Wishbone slave: returns data equal to the address, ack after dly wait cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.ack = 1'b0;
        bus.dat_sm = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.ack = 1'b0;
                wcnt = 0;
            end else if (bus.ack) begin
                bus.ack = 1'b0;
                wcnt = bus.stb ? 1 : 0;
            end else if (bus.stb) begin
                if (wcnt >= dly) begin
                    bus.ack = 1'b1;
                    bus.dat_sm = bus.adr;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Reference model: tracks the next pixel index and why the bus is paused.
    initial begin
        bit m_stb;
        bit w;
        int m_idx;
        int m_run;
        int m_why;
        m_stb = 0;
        m_idx = 0;
        m_run = 0;
        m_why = W_OFF;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_stb", bus.stb, 0);
                check("rst_cyc", bus.cyc, 0);
                check("rst_fifo_write", fifo_write, 0);
                check("rst_frame_done", frame_done, 0);
                check("rst_adr", bus.adr, 0);
                m_stb = 0;
                m_idx = 0;
                m_run = 0;
                m_why = W_OFF;
            end else begin
                check("stb", bus.stb, m_stb);
                check("cyc", bus.cyc, m_stb);
                check("we", bus.we, 0);
                check("sel", bus.sel, 4'hf);
                check("cti", bus.cti, 0);
                check("bte", bus.bte, 0);
                check("dat_ms", bus.dat_ms, 0);
                if (m_stb) check("adr", bus.adr, m_idx * 4);
                w = m_stb && bus.ack;
                check("fifo_write", fifo_write, w);
                if (w) check("fifo_wdata", fifo_wdata, m_idx * 4);
                check("frame_done", frame_done, w && (m_idx == NPIX - 1));
                if (m_stb) begin
                    if (bus.ack) begin
                        m_idx = (m_idx + 1) % NPIX;
                        m_run++;
                        if (!enable) begin
                            m_idx = 0;
                            m_why = W_OFF;
                            m_stb = 0;
                        end else if (fifo_afull) begin
                            m_why = W_ROOM;
                            m_stb = 0;
                        end else if (m_run == BR) begin
                            m_why = W_GAP;
                            m_stb = 0;
                        end
                    end
                end else begin
                    case (m_why)
                        W_OFF: m_stb = enable;
                        W_GAP: m_stb = 1;
                        default: begin
                            if (!enable) begin
                                m_why = W_OFF;
                                m_idx = 0;
                            end else begin
                                m_stb = !fifo_afull;
                            end
                        end
                    endcase
                    if (m_stb) m_run = 0;
                end
            end
        end
    end

    task do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int exp1[14];
        int pushes[$];
        int fd_at;
        int st;
        bit found;
        logic after16_stb;
        logic [31:0] after_gap_adr;

        exp1 = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 0, 4};
        rst = 1'b1;
        enable = 1'b0;
        fifo_afull = 1'b0;
        dly = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full frame plus wrap, burst gap after the fifth ack.
        enable = 1'b1;
        fd_at = -1;
        st = 0;
        after16_stb = 1'bx;
        after_gap_adr = 'x;
        for (int c = 0; c < 200 && pushes.size() < 14; c++) begin
            @(negedge clk);
            if (st == 1) begin
                after16_stb = bus.stb;
                st = 2;
            end else if (st == 2) begin
                after_gap_adr = bus.adr;
                st = 3;
            end
            if (fifo_write) begin
                pushes.push_back(int'(fifo_wdata));
                if (frame_done) fd_at = pushes.size() - 1;
                if (fifo_wdata == 32'd16 && st == 0) st = 1;
            end
        end
        check("a_push_count", pushes.size(), 14);
        for (int i = 0; i < 14; i++)
            if (i < pushes.size()) check("a_push_seq", pushes[i], exp1[i]);
        check("a_frame_done_idx", fd_at, 11);
        check("a_gap_after16", after16_stb, 0);
        check("a_adr_after_gap", after_gap_adr, 20);

        // FIFO almost-full raised on the ack of the transfer to address 8.
        do_reset;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (bus.stb && !bus.ack && bus.adr == 32'd8) found = 1;
        end
        check("b_reach_adr8", found, 1);
        @(posedge clk);
        #1 fifo_afull = 1'b1;
        @(negedge clk);
        check("b_push_wr", fifo_write, 1);
        check("b_push_dat", fifo_wdata, 8);
        repeat (4) begin
            @(negedge clk);
            check("b_hold_stb", bus.stb, 0);
        end
        @(posedge clk);
        #1 fifo_afull = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.stb) found = 1;
        end
        check("b_resume", found, 1);
        check("b_resume_adr", bus.adr, 12);

        // enable dropped while a slow transfer is outstanding.
        dly = 3;
        do_reset;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (bus.stb && !bus.ack && bus.adr == 32'd4) found = 1;
        end
        check("c_reach_adr4", found, 1);
        @(posedge clk);
        #1 enable = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (fifo_write) found = 1;
        end
        check("c_pending_push", found, 1);
        check("c_pending_dat", fifo_wdata, 4);
        repeat (3) begin
            @(negedge clk);
            check("c_idle_stb", bus.stb, 0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.stb) found = 1;
        end
        check("c_restart", found, 1);
        check("c_restart_adr", bus.adr, 0);

        // Reset pulse in the middle of a transfer.
        dly = 1;
        do_reset;
        found = 0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            if (bus.stb && !bus.ack && bus.adr == 32'd20) found = 1;
        end
        check("d_reach_adr20", found, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("d_rst_stb", bus.stb, 0);
        check("d_rst_cyc", bus.cyc, 0);
        check("d_rst_fifo_write", fifo_write, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.stb) found = 1;
        end
        check("d_restart", found, 1);
        check("d_restart_adr", bus.adr, 0);

        // Randomized traffic: slave latency, almost-full, enable and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            dly = $urandom_range(0, 3);
            if ($urandom_range(0, 99) < 12) fifo_afull = !fifo_afull;
            if (enable) begin
                if ($urandom_range(0, 99) < 2) enable = 1'b0;
            end else if ($urandom_range(0, 99) < 25) begin
                enable = 1'b1;
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 999) < 4) rst = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
